// File: rtl/scan2d_pkg.sv
// scan2d_pkg: shared types and defaults for the 2-D scan sequencer.
//   state_t   : sequencer FSM states (IDLE, RUN, DONE)
//   XW_DEF/YW_DEF : default coordinate widths
package scan2d_pkg;
  localparam int XW_DEF = 8;
  localparam int YW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/scan2d_if.sv
// scan2d_if: control and coordinate-stream signals of the scan sequencer.
//   control : start, abort, x_max, y_max  (to sequencer); busy, done (from)
//   stream  : out_valid, out_x, out_y, out_eol, out_last (from); out_ready (to)
//   master  : sequencer side; slave : control/consumer side.
interface scan2d_if #(
  parameter int XW = 8,
  parameter int YW = 8
);
  logic          start;
  logic          abort;
  logic [XW-1:0] x_max;
  logic [YW-1:0] y_max;
  logic          out_ready;
  logic          out_valid;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic          out_eol;
  logic          out_last;
  logic          busy;
  logic          done;

  modport master (
    input  start, abort, x_max, y_max, out_ready,
    output out_valid, out_x, out_y, out_eol, out_last, busy, done
  );

  modport slave (
    output start, abort, x_max, y_max, out_ready,
    input  out_valid, out_x, out_y, out_eol, out_last, busy, done
  );
endinterface

// File: rtl/scan_axis_counter.sv
// scan_axis_counter: one wrap-around axis of the raster scan.
//   clk, rst_n : clock, synchronous active-low reset
//   i_en       : advance one step
//   i_clr      : restart at 0 (has priority over i_en)
//   i_limit    : latched last index of this axis
//   i_down     : count toward 0 instead of toward i_limit
//   o_cnt      : current index
//   o_at_end   : index is the end of the axis in the current direction
//   o_wrap     : i_en && o_at_end
// HOLD_AT_END=1 keeps the count at the end point on wrap, so a serpentine
// row that ends at x_max starts the next (reversed) row at x_max.
module scan_axis_counter #(
  parameter int W           = 8,
  parameter bit HOLD_AT_END = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_limit,
  input  logic         i_down,
  output logic [W-1:0] o_cnt,
  output logic         o_at_end,
  output logic         o_wrap
);
  logic [W-1:0] r_cnt;

  assign o_cnt    = r_cnt;
  assign o_at_end = i_down ? (r_cnt == '0) : (r_cnt == i_limit);
  assign o_wrap   = i_en && o_at_end;

  always_ff @(posedge clk) begin
    if (!rst_n)          r_cnt <= '0;
    else if (i_clr)      r_cnt <= '0;
    else if (i_en) begin
      if (o_at_end)      r_cnt <= HOLD_AT_END ? r_cnt : '0;
      else if (i_down)   r_cnt <= r_cnt - 1'b1;
      else               r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/scan2d_sequencer.sv
// scan2d_sequencer: emits one frame of (x,y) coordinates per start pulse as
// a valid/ready stream, X inner / Y outer, then a one-cycle done pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : scan2d_if.master (start/abort/x_max/y_max in, stream and
//                busy/done out)
// Build option: SCAN2D_SERPENTINE_EN selects a serpentine scan (odd rows run
// x_max..0); undefined gives a plain raster with no direction logic.
module scan2d_sequencer
  import scan2d_pkg::*;
#(
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  scan2d_if.master  bus
);
  state_t        r_state, w_state_nxt;
  logic [XW-1:0] r_x_max;
  logic [YW-1:0] r_y_max;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_x_end, w_y_end, w_x_wrap, w_y_wrap;
  logic          w_run, w_start_acc, w_x_en, w_x_down;

  assign w_run       = (r_state == RUN);
  assign w_start_acc = (r_state == IDLE) && bus.start;
  // abort wins over a same-cycle transfer: the counters must not move.
  assign w_x_en      = w_run && !bus.abort && bus.out_ready;

`ifdef SCAN2D_SERPENTINE_EN
  localparam bit SNAKE = 1'b1;
  assign w_x_down = w_y[0];
`else
  localparam bit SNAKE = 1'b0;
  assign w_x_down = 1'b0;
`endif

  scan_axis_counter #(.W(XW), .HOLD_AT_END(SNAKE)) u_x (
    .clk(clk), .rst_n(rst_n), .i_en(w_x_en), .i_clr(w_start_acc),
    .i_limit(r_x_max), .i_down(w_x_down),
    .o_cnt(w_x), .o_at_end(w_x_end), .o_wrap(w_x_wrap)
  );

  // Y only moves on an X wrap, so a Y wrap is exactly the final transfer.
  scan_axis_counter #(.W(YW), .HOLD_AT_END(1'b0)) u_y (
    .clk(clk), .rst_n(rst_n), .i_en(w_x_wrap), .i_clr(w_start_acc),
    .i_limit(r_y_max), .i_down(1'b0),
    .o_cnt(w_y), .o_at_end(w_y_end), .o_wrap(w_y_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_x_max <= '0;
      r_y_max <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_x_max <= bus.x_max;
        r_y_max <= bus.y_max;
      end
    end
  end

  // Coordinates are zeroed outside RUN so idle/reset outputs read as 0.
  always_comb begin
    w_state_nxt   = r_state;
    bus.out_valid = 1'b0;
    bus.out_x     = '0;
    bus.out_y     = '0;
    bus.out_eol   = 1'b0;
    bus.out_last  = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = RUN;
      RUN: begin
        bus.out_valid = 1'b1;
        bus.out_x     = w_x;
        bus.out_y     = w_y;
        bus.out_eol   = w_x_end;
        bus.out_last  = w_x_end && w_y_end;
        bus.busy      = 1'b1;
        if (bus.abort)     w_state_nxt = IDLE;
        else if (w_y_wrap) w_state_nxt = DONE;
      end
      DONE: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_scan2d_sequencer.sv
// tb_scan2d_sequencer: directed and randomized frames checked against a
// coordinate-list reference model built from the scan rules.
module tb_scan2d_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scan2d_if #(.XW(8), .YW(8)) bus();
  scan2d_sequencer #(.XW(8), .YW(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef SCAN2D_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif

  typedef struct { int x; int y; bit eol; bit last; } beat_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    // only used for simple scalar comparisons made inline by callers
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic all_zero(input string name);
    n_tests++;
    if ({bus.out_valid, bus.out_x, bus.out_y, bus.out_eol, bus.out_last, bus.busy, bus.done} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs v=%b x=%0d y=%0d eol=%b last=%b busy=%b done=%b expected all 0",
               name, bus.out_valid, bus.out_x, bus.out_y, bus.out_eol, bus.out_last, bus.busy, bus.done);
    end
  endtask

  // rmode: 0 ready=1, 1 ready toggles 1/0, 2 random. noise: random start and
  // limit changes while the frame runs, plus start held in the DONE cycle.
  task automatic run_frame(input int xm, input int ym, input int rmode, input bit noise);
    beat_t q[$];
    beat_t b;
    int cyc, beats, px, py;
    bit done_seen, rdy, pstall;
    for (int y = 0; y <= ym; y++)
      for (int i = 0; i <= xm; i++) begin
        b.x = (SERP && y[0]) ? xm - i : i;
        b.y = y;
        b.eol = (i == xm);
        b.last = (i == xm) && (y == ym);
        q.push_back(b);
      end
    beats = q.size();
    bus.start = 1'b1; bus.x_max = 8'(xm); bus.y_max = 8'(ym);
    step();
    bus.start = 1'b0;
    cyc = 0; done_seen = 0; pstall = 0; px = 0; py = 0;
    while (!done_seen && cyc < 2000) begin
      case (rmode)
        0: rdy = 1'b1;
        1: rdy = ~cyc[0];
        default: rdy = 1'($urandom);
      endcase
      bus.out_ready = rdy;
      if (noise) begin
        bus.start = 1'($urandom); bus.x_max = 8'($urandom); bus.y_max = 8'($urandom);
      end
      if (bus.done) begin
        done_seen = 1;
        chk("done_valid_low", int'(bus.out_valid), 0);
        chk("done_busy", int'(bus.busy), 1);
        chk("done_all_beats_seen", q.size(), 0);
        if (rmode == 0) chk("done_cycle", cyc, beats);
        if (noise) bus.start = 1'b1;
      end else begin
        chk("valid_held", int'(bus.out_valid), 1);
        if (pstall) begin
          chk("stall_x", int'(bus.out_x), px);
          chk("stall_y", int'(bus.out_y), py);
        end
        if (q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL extra_beat: got (%0d,%0d) expected no beat", bus.out_x, bus.out_y);
        end else begin
          n_tests++;
          if (int'(bus.out_x) !== q[0].x || int'(bus.out_y) !== q[0].y ||
              bus.out_eol !== q[0].eol || bus.out_last !== q[0].last) begin
            n_fail++;
            $display("FAIL beat: got (%0d,%0d) eol=%b last=%b expected (%0d,%0d) eol=%b last=%b",
                     bus.out_x, bus.out_y, bus.out_eol, bus.out_last,
                     q[0].x, q[0].y, q[0].eol, q[0].last);
          end
          if (rdy && bus.out_valid) void'(q.pop_front());
        end
        pstall = bus.out_valid && !rdy;
        px = int'(bus.out_x); py = int'(bus.out_y);
      end
      step();
      cyc++;
    end
    if (!done_seen) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: no done after %0d cycles", cyc);
    end
    bus.start = 1'b0; bus.out_ready = 1'b1;
    // IDLE after DONE; a start held during DONE must not have launched.
    all_zero("idle_after_done");
    step();
    all_zero("idle_after_done2");
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.x_max = 0; bus.y_max = 0; bus.out_ready = 1;
    rst_n = 1'b0;
    repeat (3) step();
    all_zero("reset_outputs");
    rst_n = 1'b1;
    step();
    all_zero("after_reset_idle");
  endtask

  task automatic test_raster();  run_frame(3, 2, 0, 0); endtask
  task automatic test_stall();   run_frame(1, 1, 1, 0); endtask
  task automatic test_single();  run_frame(0, 0, 0, 0); endtask
  task automatic test_ignored(); run_frame(2, 3, 2, 1); endtask

  task automatic test_abort();
    bit found = 0;
    bus.abort = 1'b1;             // abort in IDLE has no effect
    step();
    all_zero("abort_in_idle");
    bus.abort = 1'b0;
    bus.start = 1'b1; bus.x_max = 3; bus.y_max = 2; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.out_valid && bus.out_x == 2 && bus.out_y == 1) found = 1;
      else step();
    end
    chk("abort_point_reached", int'(found), 1);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    all_zero("abort_next_cycle");
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", int'(bus.done), 0);
      step();
    end
    run_frame(1, 1, 0, 0);
  endtask

  task automatic test_mid_reset();
    bus.start = 1'b1; bus.x_max = 4; bus.y_max = 4; bus.out_ready = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("pre_reset_valid", int'(bus.out_valid), 1);
    rst_n = 1'b0;
    step();
    all_zero("mid_reset_outputs");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      all_zero("post_reset_idle");
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++)
      run_frame(int'($urandom_range(0, 5)), int'($urandom_range(0, 4)), 2, 1'($urandom));
  endtask

  initial begin
    test_reset();
    test_raster();
    test_stall();
    test_single();
    test_abort();
    test_ignored();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
